// File: rtl/apb_timer_pkg.sv
// -----------------------------------------------------------------------------
// apb_timer_pkg
// Shared definitions for the APB timer scheduler slice.
//   REG_TIMER/REG_CTRL/REG_CMP : byte offsets of the timer registers
//   sched_state_e              : scheduler FSM states
//   done_status_e              : completion status reported with done_o
// -----------------------------------------------------------------------------
package apb_timer_pkg;

    localparam logic [7:0] REG_TIMER = 8'h00;
    localparam logic [7:0] REG_CTRL  = 8'h04;
    localparam logic [7:0] REG_CMP   = 8'h08;

    typedef enum logic [3:0] {
        IDLE,
        CTRL_SETUP,
        CTRL_ACC,
        CMP_SETUP,
        CMP_ACC,
        WAIT,
        DIS_SETUP,
        DIS_ACC,
        DONE
    } sched_state_e;

    typedef enum logic [1:0] {
        OK     = 2'b00,
        SLVERR = 2'b01,
        CANCEL = 2'b10
    } done_status_e;

endpackage

// File: rtl/apb_timer_rr_arb.sv
// -----------------------------------------------------------------------------
// apb_timer_rr_arb
// Combinational round-robin picker: grants the first asserted request at or
// after the pointer, wrapping around NUM_REQ. The pointer register is owned
// by the caller.
//   req_i       in  NUM_REQ  request vector
//   ptr_i       in  IDX_W    search start position
//   grant_o     out NUM_REQ  one-hot grant
//   grant_idx_o out IDX_W    index of the granted request
//   any_o       out 1        at least one request asserted
// -----------------------------------------------------------------------------
module apb_timer_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               any_o
);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] idx;

    // Walk the channels starting at the pointer; the first hit wins and
    // later hits are masked by any_o. The extra position bit lets the wrap
    // work for channel counts that are not a power of two.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_o       = 1'b0;
        pos         = '0;
        idx         = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pos = {1'b0, ptr_i} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQ)) begin
                pos = pos - (IDX_W+1)'(NUM_REQ);
            end
            idx = pos[IDX_W-1:0];
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/apb_timer_sched.sv
// -----------------------------------------------------------------------------
// apb_timer_sched
// Shares one APB compare timer among NUM_REQ requesters. A request is granted
// round-robin, the timer is programmed (CTRL = prescaler, CMP = ticks), the
// compare IRQ (or a cancel from the owner) is awaited, the compare is disarmed
// by writing CMP = 0, and a one-cycle done pulse with status goes to the owner.
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   req_valid_i    per-channel request;  req_ready_o one-hot accept
//   req_ticks_i    per-channel compare value (32 bits each, packed)
//   req_presc_i    per-channel prescaler value (32 bits each, packed)
//   req_cancel_i   level cancel, honoured only for the owner in WAIT
//   done_o         one-cycle completion pulse to the owner
//   done_status_o  00 ok, 01 slave error, 10 cancelled
//   busy_o         a timeout is in progress
//   PADDR..PENABLE write-only APB master towards the timer
//   PREADY/PSLVERR APB slave response
//   irq_cmp_i      timer compare-match pulse
// -----------------------------------------------------------------------------
module apb_timer_sched
    import apb_timer_pkg::*;
#(
    parameter int                        NUM_REQ        = 4,
    parameter int                        APB_ADDR_WIDTH = 12,
    parameter logic [APB_ADDR_WIDTH-1:0] TIMER_BASE     = '0
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic [NUM_REQ*32-1:0]     req_ticks_i,
    input  logic [NUM_REQ*32-1:0]     req_presc_i,
    input  logic [NUM_REQ-1:0]        req_cancel_i,
    output logic [NUM_REQ-1:0]        done_o,
    output logic [1:0]                done_status_o,
    output logic                      busy_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    input  logic                      irq_cmp_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CTRL = TIMER_BASE + APB_ADDR_WIDTH'(REG_CTRL);
    localparam logic [APB_ADDR_WIDTH-1:0] ADDR_CMP  = TIMER_BASE + APB_ADDR_WIDTH'(REG_CMP);

    sched_state_e     state_q, state_d;
    done_status_e     status_q, status_d;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_ptr_q;
    logic [31:0]      ticks_q;
    logic [31:0]      presc_q;

    logic [NUM_REQ-1:0] arb_grant;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_any;
    logic               grant_fire;

    logic [31:0] ticks_arr [NUM_REQ];
    logic [31:0] presc_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign ticks_arr[g] = req_ticks_i[g*32 +: 32];
        assign presc_arr[g] = req_presc_i[g*32 +: 32];
    end

    apb_timer_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i       (req_valid_i),
        .ptr_i       (rr_ptr_q),
        .grant_o     (arb_grant),
        .grant_idx_o (arb_idx),
        .any_o       (arb_any)
    );

    // State, status and the request snapshot. The snapshot (owner, ticks,
    // prescaler) is only taken on a grant, so requesters may change their
    // inputs freely afterwards. The pointer moves past the winner so the
    // next search starts at the following channel.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            status_q <= OK;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            ticks_q  <= '0;
            presc_q  <= '0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            if (grant_fire) begin
                owner_q  <= arb_idx;
                ticks_q  <= ticks_arr[arb_idx];
                presc_q  <= presc_arr[arb_idx];
                rr_ptr_q <= (arb_idx == IDX_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
            end
        end
    end

    // Next state and all outputs. The bus outputs are decoded from the state
    // alone, so an asynchronous reset drops PSEL/PENABLE immediately. Each
    // write is a SETUP state followed by an ACCESS state that holds until
    // PREADY; address and data come from the state, so they cannot move
    // during a stalled access.
    always_comb begin
        state_d       = state_q;
        status_d      = status_q;
        grant_fire    = 1'b0;
        req_ready_o   = '0;
        done_o        = '0;
        done_status_o = 2'b00;
        busy_o        = (state_q != IDLE);
        PSEL          = 1'b0;
        PENABLE       = 1'b0;
        PADDR         = '0;
        PWDATA        = '0;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    grant_fire  = 1'b1;
                    req_ready_o = arb_grant;
                    status_d    = OK;
                    state_d     = (ticks_arr[arb_idx] == 32'd0) ? DONE : CTRL_SETUP;
                end
            end
            CTRL_SETUP: begin
                PSEL    = 1'b1;
                PADDR   = ADDR_CTRL;
                PWDATA  = presc_q;
                state_d = CTRL_ACC;
            end
            CTRL_ACC: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PADDR   = ADDR_CTRL;
                PWDATA  = presc_q;
                if (PREADY) begin
                    if (PSLVERR) begin
                        status_d = SLVERR;
                        state_d  = DIS_SETUP;
                    end else begin
                        state_d  = CMP_SETUP;
                    end
                end
            end
            CMP_SETUP: begin
                PSEL    = 1'b1;
                PADDR   = ADDR_CMP;
                PWDATA  = ticks_q;
                state_d = CMP_ACC;
            end
            CMP_ACC: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PADDR   = ADDR_CMP;
                PWDATA  = ticks_q;
                if (PREADY) begin
                    if (PSLVERR) begin
                        status_d = SLVERR;
                        state_d  = DIS_SETUP;
                    end else begin
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                // The IRQ is checked first so a simultaneous cancel loses.
                if (irq_cmp_i) begin
                    status_d = OK;
                    state_d  = DIS_SETUP;
                end else if (req_cancel_i[owner_q]) begin
                    status_d = CANCEL;
                    state_d  = DIS_SETUP;
                end
            end
            DIS_SETUP: begin
                PSEL    = 1'b1;
                PADDR   = ADDR_CMP;
                state_d = DIS_ACC;
            end
            DIS_ACC: begin
                // A slave error on the disarm does not replace the status
                // already decided for this timeout.
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                PADDR   = ADDR_CMP;
                if (PREADY) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_o[owner_q] = 1'b1;
                done_status_o   = status_q;
                state_d         = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        PWRITE = PSEL;
    end

endmodule

// File: tb/tb_apb_timer_sched.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_sched
// Directed bench for apb_timer_sched (NUM_REQ=4, 12-bit PADDR, base 0).
// The bench acts as the requesters, the timer slave response and the IRQ
// source; expected values are written out cycle by cycle below.
// -----------------------------------------------------------------------------
module tb_apb_timer_sched;

    localparam int NUM_REQ = 4;
    localparam int AW      = 12;

    logic                  HCLK = 1'b0;
    logic                  HRESETn;
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_ticks;
    logic [NUM_REQ*32-1:0] req_presc;
    logic [NUM_REQ-1:0]    req_cancel;
    logic [NUM_REQ-1:0]    done;
    logic [1:0]            done_status;
    logic                  busy;
    logic [AW-1:0]         PADDR;
    logic [31:0]           PWDATA;
    logic                  PWRITE;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PREADY;
    logic                  PSLVERR;
    logic                  irq_cmp;

    int n_checks = 0;
    int n_fail   = 0;
    int wr_base  = 0;

    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   wr_data_q [$];

    apb_timer_sched #(
        .NUM_REQ        (NUM_REQ),
        .APB_ADDR_WIDTH (AW),
        .TIMER_BASE     (12'h000)
    ) dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_ticks_i   (req_ticks),
        .req_presc_i   (req_presc),
        .req_cancel_i  (req_cancel),
        .done_o        (done),
        .done_status_o (done_status),
        .busy_o        (busy),
        .PADDR         (PADDR),
        .PWDATA        (PWDATA),
        .PWRITE        (PWRITE),
        .PSEL          (PSEL),
        .PENABLE       (PENABLE),
        .PREADY        (PREADY),
        .PSLVERR       (PSLVERR),
        .irq_cmp_i     (irq_cmp)
    );

    always #5 HCLK = ~HCLK;

    // Log every completed APB write so whole-transaction sequences can be
    // compared after each scenario.
    always @(posedge HCLK) begin
        if (HRESETn && PSEL && PENABLE && PREADY) begin
            wr_addr_q.push_back(PADDR);
            wr_data_q.push_back(PWDATA);
        end
    end

    // Safety net so the run can never hang.
    initial begin
        #50000;
        $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkApb(input string tag, input logic psel, input logic pen,
                            input logic [AW-1:0] addr, input logic [31:0] data);
        checkOutput({tag, " PSEL"}, 32'(PSEL), 32'(psel));
        checkOutput({tag, " PENABLE"}, 32'(PENABLE), 32'(pen));
        checkOutput({tag, " PWRITE"}, 32'(PWRITE), 32'(psel));
        if (psel) begin
            checkOutput({tag, " PADDR"}, 32'(PADDR), 32'(addr));
            checkOutput({tag, " PWDATA"}, PWDATA, data);
        end
    endtask

    task automatic checkWrites(input string tag, input int n,
                               input logic [AW-1:0] a0, input logic [31:0] d0,
                               input logic [AW-1:0] a1, input logic [31:0] d1,
                               input logic [AW-1:0] a2, input logic [31:0] d2);
        logic [AW-1:0] ea [3];
        logic [31:0]   ed [3];
        int            got;
        ea[0] = a0; ea[1] = a1; ea[2] = a2;
        ed[0] = d0; ed[1] = d1; ed[2] = d2;
        got = wr_addr_q.size() - wr_base;
        checkOutput({tag, " write count"}, 32'(got), 32'(n));
        for (int i = 0; i < n && i < got; i++) begin
            checkOutput($sformatf("%s write%0d addr", tag, i), 32'(wr_addr_q[wr_base+i]), 32'(ea[i]));
            checkOutput($sformatf("%s write%0d data", tag, i), wr_data_q[wr_base+i], ed[i]);
        end
        wr_base = wr_addr_q.size();
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic applyStimulus(input int ch, input logic [31:0] ticks, input logic [31:0] presc);
        req_valid[ch]          = 1'b1;
        req_ticks[ch*32 +: 32] = ticks;
        req_presc[ch*32 +: 32] = presc;
    endtask

    task automatic applyReset();
        HRESETn    = 1'b0;
        req_valid  = '0;
        req_cancel = '0;
        PREADY     = 1'b1;
        PSLVERR    = 1'b0;
        irq_cmp    = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        wr_base = wr_addr_q.size();
    endtask

    initial begin
        req_ticks = '0;
        req_presc = '0;
        HRESETn   = 1'b0;
        req_valid = '0;
        req_cancel = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        irq_cmp   = 1'b0;
        #1;
        checkOutput("reset PSEL", 32'(PSEL), 32'h0);
        checkOutput("reset PENABLE", 32'(PENABLE), 32'h0);
        checkOutput("reset PWRITE", 32'(PWRITE), 32'h0);
        checkOutput("reset PADDR", 32'(PADDR), 32'h0);
        checkOutput("reset PWDATA", PWDATA, 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        checkOutput("reset done", 32'(done), 32'h0);
        checkOutput("reset status", 32'(done_status), 32'h0);
        checkOutput("reset ready", 32'(req_ready), 32'h0);
        applyReset();
        #1;

        // ---- Single request ch0 ticks=5 presc=0, IRQ 6 cycles after CMP access
        applyStimulus(0, 32'd5, 32'd0);
        #1;
        checkOutput("t1 grant ready", 32'(req_ready), 32'h1);
        checkOutput("t1 grant busy", 32'(busy), 32'h0);
        cyc(); req_valid = '0; #1;
        checkApb("t1 ctrl setup", 1'b1, 1'b0, 12'h004, 32'd0);
        checkOutput("t1 busy", 32'(busy), 32'h1);
        checkOutput("t1 ready after grant", 32'(req_ready), 32'h0);
        cyc(); #1;
        checkApb("t1 ctrl access", 1'b1, 1'b1, 12'h004, 32'd0);
        cyc(); #1;
        checkApb("t1 cmp setup", 1'b1, 1'b0, 12'h008, 32'd5);
        cyc(); #1;
        checkApb("t1 cmp access", 1'b1, 1'b1, 12'h008, 32'd5);
        cyc(); #1;
        checkApb("t1 wait", 1'b0, 1'b0, 12'h000, 32'd0);
        repeat (4) cyc();
        cyc(); irq_cmp = 1'b1; #1;
        checkOutput("t1 irq cycle busy", 32'(busy), 32'h1);
        cyc(); irq_cmp = 1'b0; #1;
        checkApb("t1 dis setup", 1'b1, 1'b0, 12'h008, 32'd0);
        checkOutput("t1 no early done", 32'(done), 32'h0);
        cyc(); #1;
        checkApb("t1 dis access", 1'b1, 1'b1, 12'h008, 32'd0);
        cyc(); #1;
        checkOutput("t1 done", 32'(done), 32'h1);
        checkOutput("t1 status", 32'(done_status), 32'h0);
        checkApb("t1 done bus idle", 1'b0, 1'b0, 12'h000, 32'd0);
        cyc(); #1;
        checkOutput("t1 done pulse ends", 32'(done), 32'h0);
        checkOutput("t1 idle busy", 32'(busy), 32'h0);
        checkWrites("t1", 3, 12'h004, 32'd0, 12'h008, 32'd5, 12'h008, 32'd0);

        // ---- All four channels with ticks=0: round-robin, done 1 cycle after grant
        applyReset();
        applyStimulus(0, 32'd0, 32'd0);
        applyStimulus(1, 32'd0, 32'd0);
        applyStimulus(2, 32'd0, 32'd0);
        applyStimulus(3, 32'd0, 32'd0);
        #1;
        checkOutput("t2 grant0", 32'(req_ready), 32'h1);
        checkOutput("t2 grant0 bus", 32'(PSEL), 32'h0);
        cyc(); req_valid = 4'b1111; #1;
        checkOutput("t2 done0", 32'(done), 32'h1);
        checkOutput("t2 status0", 32'(done_status), 32'h0);
        checkOutput("t2 no grant in done", 32'(req_ready), 32'h0);
        checkOutput("t2 ticks0 no bus", 32'(PSEL), 32'h0);
        cyc(); #1;
        checkOutput("t2 grant1", 32'(req_ready), 32'h2);
        cyc(); req_valid = 4'b1101; #1;
        checkOutput("t2 done1", 32'(done), 32'h2);
        cyc(); #1;
        checkOutput("t2 grant2", 32'(req_ready), 32'h4);
        cyc(); req_valid = 4'b1001; #1;
        checkOutput("t2 done2", 32'(done), 32'h4);
        cyc(); #1;
        checkOutput("t2 grant3", 32'(req_ready), 32'h8);
        cyc(); req_valid = 4'b0001; #1;
        checkOutput("t2 done3", 32'(done), 32'h8);
        cyc(); #1;
        checkOutput("t2 grant0 again", 32'(req_ready), 32'h1);
        cyc(); req_valid = '0; #1;
        checkOutput("t2 done0 again", 32'(done), 32'h1);
        cyc(); #1;
        checkOutput("t2 idle busy", 32'(busy), 32'h0);
        checkOutput("t2 idle ready", 32'(req_ready), 32'h0);
        checkWrites("t2", 0, '0, '0, '0, '0, '0, '0);

        // ---- ch1 ticks=7 presc=3, PREADY low 3 cycles on CMP, stray IRQ in CTRL
        applyStimulus(1, 32'd7, 32'd3);
        #1;
        checkOutput("t3 grant", 32'(req_ready), 32'h2);
        cyc(); req_valid = '0; irq_cmp = 1'b1; #1;
        checkApb("t3 ctrl setup", 1'b1, 1'b0, 12'h004, 32'd3);
        cyc(); irq_cmp = 1'b0; #1;
        checkApb("t3 ctrl access", 1'b1, 1'b1, 12'h004, 32'd3);
        cyc(); PREADY = 1'b0; #1;
        checkApb("t3 cmp setup", 1'b1, 1'b0, 12'h008, 32'd7);
        cyc(); #1;
        checkApb("t3 stall1", 1'b1, 1'b1, 12'h008, 32'd7);
        cyc(); #1;
        checkApb("t3 stall2", 1'b1, 1'b1, 12'h008, 32'd7);
        cyc(); #1;
        checkApb("t3 stall3", 1'b1, 1'b1, 12'h008, 32'd7);
        cyc(); PREADY = 1'b1; #1;
        checkApb("t3 access ready", 1'b1, 1'b1, 12'h008, 32'd7);
        cyc(); irq_cmp = 1'b1; #1;
        checkApb("t3 wait", 1'b0, 1'b0, 12'h000, 32'd0);
        checkOutput("t3 wait busy", 32'(busy), 32'h1);
        cyc(); irq_cmp = 1'b0; #1;
        checkApb("t3 dis setup", 1'b1, 1'b0, 12'h008, 32'd0);
        cyc(); #1;
        checkApb("t3 dis access", 1'b1, 1'b1, 12'h008, 32'd0);
        cyc(); #1;
        checkOutput("t3 done", 32'(done), 32'h2);
        checkOutput("t3 status", 32'(done_status), 32'h0);
        checkWrites("t3", 3, 12'h004, 32'd3, 12'h008, 32'd7, 12'h008, 32'd0);

        // ---- ch3 ticks=9 presc=1, PSLVERR on CTRL: straight to disarm, status 01
        cyc();
        applyStimulus(3, 32'd9, 32'd1);
        #1;
        checkOutput("t4 grant", 32'(req_ready), 32'h8);
        cyc(); req_valid = '0; #1;
        checkApb("t4 ctrl setup", 1'b1, 1'b0, 12'h004, 32'd1);
        cyc(); PSLVERR = 1'b1; #1;
        checkApb("t4 ctrl access", 1'b1, 1'b1, 12'h004, 32'd1);
        cyc(); PSLVERR = 1'b0; #1;
        checkApb("t4 dis setup", 1'b1, 1'b0, 12'h008, 32'd0);
        cyc(); #1;
        checkApb("t4 dis access", 1'b1, 1'b1, 12'h008, 32'd0);
        cyc(); #1;
        checkOutput("t4 done", 32'(done), 32'h8);
        checkOutput("t4 status", 32'(done_status), 32'h1);
        checkWrites("t4", 2, 12'h004, 32'd1, 12'h008, 32'd0, '0, '0);

        // ---- ch2 ticks=1000, ch1 cancel ignored, ch2 cancel honoured,
        //      PSLVERR on the disarm keeps the cancel status
        cyc();
        applyStimulus(2, 32'd1000, 32'd0);
        #1;
        checkOutput("t5 grant", 32'(req_ready), 32'h4);
        cyc(); req_valid = '0;
        repeat (4) cyc();
        #1;
        checkApb("t5 wait", 1'b0, 1'b0, 12'h000, 32'd0);
        cyc(); req_cancel = 4'b0010; #1;
        checkOutput("t5 foreign cancel busy", 32'(busy), 32'h1);
        cyc(); #1;
        checkApb("t5 foreign cancel ignored", 1'b0, 1'b0, 12'h000, 32'd0);
        req_cancel = 4'b0110; #1;
        cyc(); req_cancel = '0; #1;
        checkApb("t5 dis setup", 1'b1, 1'b0, 12'h008, 32'd0);
        cyc(); PSLVERR = 1'b1; #1;
        checkApb("t5 dis access", 1'b1, 1'b1, 12'h008, 32'd0);
        cyc(); PSLVERR = 1'b0; #1;
        checkOutput("t5 done", 32'(done), 32'h4);
        checkOutput("t5 status", 32'(done_status), 32'h2);
        checkWrites("t5", 3, 12'h004, 32'd0, 12'h008, 32'd1000, 12'h008, 32'd0);

        // ---- ch3 ticks=4 presc=2, cancel raised early, IRQ and cancel together
        cyc();
        applyStimulus(3, 32'd4, 32'd2);
        #1;
        checkOutput("t6 grant", 32'(req_ready), 32'h8);
        cyc(); req_valid = '0; req_cancel = 4'b1000; #1;
        checkApb("t6 ctrl setup", 1'b1, 1'b0, 12'h004, 32'd2);
        cyc();
        cyc(); #1;
        checkApb("t6 cmp setup", 1'b1, 1'b0, 12'h008, 32'd4);
        cyc();
        cyc(); irq_cmp = 1'b1; #1;
        checkOutput("t6 wait busy", 32'(busy), 32'h1);
        cyc(); irq_cmp = 1'b0; req_cancel = '0; #1;
        checkApb("t6 dis setup", 1'b1, 1'b0, 12'h008, 32'd0);
        cyc(); cyc(); #1;
        checkOutput("t6 done", 32'(done), 32'h8);
        checkOutput("t6 irq wins status", 32'(done_status), 32'h0);

        // ---- ch0 ticks=10, reset in WAIT, then a fresh request from CTRL_SETUP
        cyc();
        applyStimulus(0, 32'd10, 32'd0);
        #1;
        checkOutput("t7 grant", 32'(req_ready), 32'h1);
        cyc(); req_valid = '0;
        repeat (4) cyc();
        #1;
        checkOutput("t7 wait busy", 32'(busy), 32'h1);
        #2;
        HRESETn = 1'b0;
        #1;
        checkOutput("t7 reset busy", 32'(busy), 32'h0);
        checkApb("t7 reset bus", 1'b0, 1'b0, 12'h000, 32'd0);
        checkOutput("t7 reset done", 32'(done), 32'h0);
        cyc(); irq_cmp = 1'b1;
        cyc(); irq_cmp = 1'b0; HRESETn = 1'b1; #1;
        checkOutput("t7 no done after reset", 32'(done), 32'h0);
        checkOutput("t7 idle after reset", 32'(busy), 32'h0);
        applyStimulus(1, 32'd3, 32'd5);
        #1;
        checkOutput("t7 grant after reset", 32'(req_ready), 32'h2);
        cyc(); req_valid = '0; #1;
        checkApb("t7 restart ctrl setup", 1'b1, 1'b0, 12'h004, 32'd5);
        #2;
        HRESETn = 1'b0;
        #1;
        checkApb("t7 async drop", 1'b0, 1'b0, 12'h000, 32'd0);
        cyc(); cyc();
        checkOutput("t7 no done", 32'(done), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
